// File: rtl/feature_map_streamer_if.sv
// rtl/feature_map_streamer_if.sv - write bus and pixel stream bundle for feature_map_streamer
interface feature_map_streamer_if #(
  parameter int WIDTH = 21
);
  logic             wr_valid_in;
  logic [WIDTH-1:0] wr_data_in;
  logic [4:0]       wr_hcount_in;
  logic [4:0]       wr_vcount_in;
  logic             stall_in;
  logic             data_valid_out;
  logic [WIDTH-1:0] pixel_data_out;
  logic [4:0]       hcount_out;
  logic [4:0]       vcount_out;
  logic             frame_done_out;
  logic             overflow_out;

  // upstream writer and downstream consumer side
  modport master (
    output wr_valid_in, wr_data_in, wr_hcount_in, wr_vcount_in, stall_in,
    input  data_valid_out, pixel_data_out, hcount_out, vcount_out,
    input  frame_done_out, overflow_out
  );

  // streamer side
  modport slave (
    input  wr_valid_in, wr_data_in, wr_hcount_in, wr_vcount_in, stall_in,
    output data_valid_out, pixel_data_out, hcount_out, vcount_out,
    output frame_done_out, overflow_out
  );
endinterface

// File: rtl/feature_map_streamer.sv
// rtl/feature_map_streamer.sv - ping-pong map capture and raster replay (optional ZERO_PAD_EN border pad)
module feature_map_streamer #(
  parameter int WIDTH = 21,
  parameter int DIM   = 24
) (
  input logic                   clk_in,
  input logic                   rst_in,
  feature_map_streamer_if.slave bus
);
  localparam int DEPTH = DIM * DIM;
  localparam int AW    = $clog2(2 * DEPTH);
`ifdef ZERO_PAD_EN
  localparam int SPAN  = DIM + 2;
`else
  localparam int SPAN  = DIM;
`endif
  localparam logic [4:0] DIM5    = 5'(DIM);
  localparam logic [4:0] CORNER5 = 5'(DIM - 1);
  localparam logic [4:0] LAST5   = 5'(SPAN - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  // bank 0 occupies words 0..DEPTH-1, bank 1 the next DEPTH words
  logic [WIDTH-1:0] mem [0:2*DEPTH-1];

  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] full;
  logic       overflow;
  logic [0:0] state;
  logic [4:0] h_cnt;
  logic [4:0] v_cnt;

  logic          wr_hit;
  logic          wr_accept;
  logic          wr_corner;
  logic [AW-1:0] wr_addr;
  logic          issue;
  logic          last_issue;
  logic [4:0]    mem_h;
  logic [4:0]    mem_v;
  logic [AW-1:0] rd_addr;
`ifdef ZERO_PAD_EN
  logic          border;
`endif

  logic             s1_valid;
  logic [4:0]       s1_h;
  logic [4:0]       s1_v;
  logic [WIDTH-1:0] s1_data;

  // write qualification, read issue and address generation
  always_comb begin
    wr_hit    = bus.wr_valid_in && (bus.wr_hcount_in < DIM5) && (bus.wr_vcount_in < DIM5);
    wr_accept = wr_hit && !full[wr_sel];
    wr_corner = wr_accept && (bus.wr_hcount_in == CORNER5) && (bus.wr_vcount_in == CORNER5);
    wr_addr   = (wr_sel ? AW'(DEPTH) : '0) + AW'(bus.wr_vcount_in) * AW'(DIM)
              + AW'(bus.wr_hcount_in);
    issue      = (state == STREAM) && !bus.stall_in;
    last_issue = issue && (h_cnt == LAST5) && (v_cnt == LAST5);
`ifdef ZERO_PAD_EN
    // the padded frame is shifted by one so interior (h,v) maps to stored (h-1,v-1)
    border = (h_cnt == 5'd0) || (v_cnt == 5'd0) || (h_cnt == LAST5) || (v_cnt == LAST5);
    mem_h  = h_cnt - 5'd1;
    mem_v  = v_cnt - 5'd1;
`else
    mem_h  = h_cnt;
    mem_v  = v_cnt;
`endif
    rd_addr = (rd_sel ? AW'(DEPTH) : '0) + AW'(mem_v) * AW'(DIM) + AW'(mem_h);
  end

  // storage write port
  always_ff @(posedge clk_in) begin
    if (wr_accept) mem[wr_addr] <= bus.wr_data_in;
  end

  // registered read port; first of the two latency stages
  always_ff @(posedge clk_in) begin
`ifdef ZERO_PAD_EN
    if (issue) s1_data <= border ? '0 : mem[rd_addr];
`else
    if (issue) s1_data <= mem[rd_addr];
`endif
  end

  // bank bookkeeping and read FSM; fill and stream completions on opposite banks both land
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      full     <= 2'b00;
      overflow <= 1'b0;
      state    <= IDLE;
      h_cnt    <= 5'd0;
      v_cnt    <= 5'd0;
    end else begin
      if (wr_hit && full[wr_sel]) overflow <= 1'b1;
      if (wr_corner) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (last_issue) full[rd_sel] <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rd_sel]) begin
            state <= STREAM;
            h_cnt <= 5'd0;
            v_cnt <= 5'd0;
          end
        end
        STREAM: begin
          if (last_issue) begin
            state  <= IDLE;
            rd_sel <= ~rd_sel;
            h_cnt  <= 5'd0;
            v_cnt  <= 5'd0;
          end else if (issue) begin
            if (h_cnt == LAST5) begin
              h_cnt <= 5'd0;
              v_cnt <= v_cnt + 5'd1;
            end else begin
              h_cnt <= h_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // sideband pipe keeps coordinates aligned with memory data; stall never freezes it
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid           <= 1'b0;
      s1_h               <= 5'd0;
      s1_v               <= 5'd0;
      bus.data_valid_out <= 1'b0;
      bus.pixel_data_out <= '0;
      bus.hcount_out     <= 5'd0;
      bus.vcount_out     <= 5'd0;
      bus.frame_done_out <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_h <= h_cnt;
        s1_v <= v_cnt;
      end
      bus.data_valid_out <= s1_valid;
      if (s1_valid) begin
        bus.pixel_data_out <= s1_data;
        bus.hcount_out     <= s1_h;
        bus.vcount_out     <= s1_v;
      end
      bus.frame_done_out <= s1_valid && (s1_h == LAST5) && (s1_v == LAST5);
    end
  end

  assign bus.overflow_out = overflow;
endmodule

// File: tb/tb_feature_map_streamer.sv
// tb/tb_feature_map_streamer.sv - directed self-checking bench for feature_map_streamer
module tb_feature_map_streamer;
  localparam int WIDTH = 21;
  localparam int DIM   = 24;
  localparam int NPIX  = DIM * DIM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  feature_map_streamer_if #(.WIDTH(WIDTH)) bus();

  feature_map_streamer #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int lg_h[$], lg_v[$], lg_d[$], lg_c[$], lg_f[$];

  // log every valid output beat with the cycle it was seen in
  always @(negedge clk) begin
    if (bus.frame_done_out === 1'b1) n_done++;
    if (bus.data_valid_out === 1'b1) begin
      lg_h.push_back(int'(bus.hcount_out));
      lg_v.push_back(int'(bus.vcount_out));
      lg_d.push_back(int'(bus.pixel_data_out));
      lg_c.push_back(cyc);
      lg_f.push_back(int'(bus.frame_done_out));
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_px(input int h, input int v, input int d);
    bus.wr_valid_in  = 1'b1;
    bus.wr_hcount_in = 5'(h);
    bus.wr_vcount_in = 5'(v);
    bus.wr_data_in   = WIDTH'(d);
    @(negedge clk);
    bus.wr_valid_in  = 1'b0;
  endtask

  task automatic write_frame(input int base, input bit skip0);
    for (int i = 0; i < NPIX; i++)
      if (!(skip0 && i == 0)) write_px(i % DIM, i / DIM, base + i);
  endtask

  task automatic clear_log();
    lg_h.delete(); lg_v.delete(); lg_d.delete(); lg_c.delete(); lg_f.delete();
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && lg_c.size() < n; i++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int first, input int span,
                             input int base, input int d0, input bit pad);
    int errs;
    int eh, ev, ed;
    errs = 0;
    for (int i = 0; i < span * span; i++) begin
      if (first + i >= lg_h.size()) begin
        errs++;
        continue;
      end
      eh = i % span;
      ev = i / span;
      if (pad) ed = (eh == 0 || ev == 0 || eh == span - 1 || ev == span - 1) ? 0 : base;
      else     ed = (i == 0) ? d0 : base + i;
      if (lg_h[first+i] != eh || lg_v[first+i] != ev || lg_d[first+i] != ed ||
          lg_f[first+i] != ((i == span * span - 1) ? 1 : 0)) errs++;
    end
    check_eq(tag, errs, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, bus.data_valid_out, 0);
    check_eq({tag, "_data"}, bus.pixel_data_out, 0);
    check_eq({tag, "_hcount"}, bus.hcount_out, 0);
    check_eq({tag, "_vcount"}, bus.vcount_out, 0);
    check_eq({tag, "_done"}, bus.frame_done_out, 0);
    check_eq({tag, "_overflow"}, bus.overflow_out, 0);
  endtask

  int n_edge;
  int done_at_rst;

  initial begin
    bus.wr_valid_in  = 1'b0;
    bus.wr_data_in   = '0;
    bus.wr_hcount_in = 5'd0;
    bus.wr_vcount_in = 5'd0;
    bus.stall_in     = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

`ifdef ZERO_PAD_EN
    clear_log();
    for (int i = 0; i < NPIX; i++) write_px(i % DIM, i / DIM, 7);
    n_edge = cyc;
    wait_log((DIM + 2) * (DIM + 2), 1500);
    check_eq("pad_count", lg_c.size(), (DIM + 2) * (DIM + 2));
    check_eq("pad_latency", lg_c[0] - n_edge, 3);
    check_eq("pad_consecutive", lg_c[675] - lg_c[0], 675);
    check_frame("pad_frame", 0, DIM + 2, 7, 7, 1);
    check_eq("pad_corner0", lg_d[0], 0);
    check_eq("pad_interior_1_1", lg_d[27], 7);
    check_eq("pad_last_h", lg_h[675], 25);
    check_eq("pad_last_v", lg_v[675], 25);
    check_eq("pad_last_done", lg_f[675], 1);
    check_eq("pad_overflow", bus.overflow_out, 0);
`else
    // raster fill v*24+h with an out-of-range write that would alias onto (0,1)
    clear_log();
    for (int i = 0; i < NPIX - 1; i++) write_px(i % DIM, i / DIM, i);
    write_px(24, 0, 12345);
    write_px(DIM - 1, DIM - 1, NPIX - 1);
    n_edge = cyc;
    wait_log(NPIX, 1000);
    check_eq("t1_count", lg_c.size(), NPIX);
    check_eq("t1_latency", lg_c[0] - n_edge, 3);
    check_eq("t1_consecutive", lg_c[NPIX-1] - lg_c[0], NPIX - 1);
    check_frame("t1_frame", 0, DIM, 0, 0, 0);
    check_eq("t1_px_5_3", lg_d[3*DIM+5], 77);
    check_eq("t1_oob_ignored", lg_d[24], 24);
    check_eq("t1_hold_data", bus.pixel_data_out, NPIX - 1);
    check_eq("t1_idle_valid", bus.data_valid_out, 0);
    check_eq("t1_overflow", bus.overflow_out, 0);

    // two back-to-back frames: exactly one bubble between them
    clear_log();
    write_frame(1000, 0);
    n_edge = cyc;
    write_frame(5000, 0);
    wait_log(2 * NPIX, 1500);
    check_eq("t2_count", lg_c.size(), 2 * NPIX);
    check_eq("t2_latency", lg_c[0] - n_edge, 3);
    check_eq("t2_gap", lg_c[NPIX] - lg_c[NPIX-1], 2);
    check_frame("t2_frame_a", 0, DIM, 1000, 1000, 0);
    check_frame("t2_frame_b", NPIX, DIM, 5000, 5000, 0);
    check_eq("t2_overflow", bus.overflow_out, 0);

    // both banks full: write dropped on the very edge the streaming bank clears
    clear_log();
    write_frame(2000, 0);
    write_frame(3000, 0);
    write_px(0, 0, 9999);
    check_eq("t3_overflow_set", bus.overflow_out, 1);
    wait_log(2 * NPIX, 1500);
    write_frame(8000, 1);
    wait_log(3 * NPIX, 1500);
    check_eq("t3_count", lg_c.size(), 3 * NPIX);
    check_frame("t3_frame_a", 0, DIM, 2000, 2000, 0);
    check_frame("t3_frame_b", NPIX, DIM, 3000, 3000, 0);
    check_frame("t3_frame_stale", 2 * NPIX, DIM, 8000, 2000, 0);
    check_eq("t3_overflow_sticky", bus.overflow_out, 1);

    // ten stall cycles starting where pixel 100 would issue
    clear_log();
    write_frame(4000, 0);
    n_edge = cyc;
    repeat (101) @(negedge clk);
    bus.stall_in = 1'b1;
    repeat (10) @(negedge clk);
    bus.stall_in = 1'b0;
    wait_log(NPIX, 1000);
    check_eq("t4_count", lg_c.size(), NPIX);
    check_eq("t4_inflight", lg_c[99] - n_edge, 102);
    check_eq("t4_gap", lg_c[100] - lg_c[99], 11);
    check_eq("t4_resume", lg_c[NPIX-1] - lg_c[100], NPIX - 101);
    check_frame("t4_frame", 0, DIM, 4000, 4000, 0);
    check_eq("t4_overflow_sticky", bus.overflow_out, 1);

    // reset in the middle of a frame
    clear_log();
    write_frame(6000, 0);
    n_edge = cyc;
    repeat (303) @(negedge clk);
    check_eq("t5_px300_h", bus.hcount_out, 12);
    check_eq("t5_px300_v", bus.vcount_out, 12);
    check_eq("t5_px300_d", bus.pixel_data_out, 6300);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("t5_after_reset");
    rst = 1'b0;
    done_at_rst = n_done;
    clear_log();
    repeat (700) @(negedge clk);
    check_eq("t5_no_valids", lg_c.size(), 0);
    check_eq("t5_no_done", n_done - done_at_rst, 0);
    write_frame(7000, 0);
    n_edge = cyc;
    wait_log(NPIX, 1000);
    check_eq("t5_count", lg_c.size(), NPIX);
    check_eq("t5_latency", lg_c[0] - n_edge, 3);
    check_frame("t5_frame", 0, DIM, 7000, 7000, 0);
    check_eq("t5_overflow", bus.overflow_out, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/feature_map_streamer.md
Name: feature_map_streamer

Overview:
- Transmit end of the pixel stream consumed by the dense layer.
- Captures a DIM x DIM map of signed 21-bit activations, written in any order by the upstream conv/pool stage, into a ping-pong BRAM pair.
- Replays each completed map in raster order as data_valid / pixel_data / hcount / vcount.
- While one bank streams out, the other bank fills.

Parameters:
- WIDTH, 21, pixel data width in bits.
- DIM, 24, map side length; legal range 2..30 (30 is the largest value that fits 5-bit coordinates once the optional 2-pixel pad is added).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- wr_valid_in  input  1  write strobe from upstream stage
- wr_data_in  input  WIDTH  activation to store
- wr_hcount_in  input  5  column of write, 0..DIM-1
- wr_vcount_in  input  5  row of write, 0..DIM-1
- stall_in  input  1  downstream pause request
- data_valid_out  output  1  pixel_data_out/hcount_out/vcount_out valid this cycle
- pixel_data_out  output  WIDTH  streamed activation
- hcount_out  output  5  column of streamed pixel
- vcount_out  output  5  row of streamed pixel
- frame_done_out  output  1  one-cycle pulse coincident with the last pixel of a frame
- overflow_out  output  1  sticky: a write was dropped

Behaviour:
- Storage: two banks of DIM*DIM words, each bank addressed as v*DIM + h.
  - BRAM has 2-cycle read latency (registered output).
- Write side:
  - wr_sel (reset 0) selects the fill bank.
  - A write with h or v >= DIM is ignored.
  - If full[wr_sel]=1, the write is dropped and overflow_out is set until reset.
  - Otherwise the word is stored.
  - A stored write at (DIM-1, DIM-1) sets full[wr_sel] and toggles wr_sel at the same edge.
  - Writes before the corner are not tracked; a missing location streams stale data.
- Read FSM, states IDLE and STREAM; rd_sel reset 0.
  - IDLE: if full[rd_sel]=1, go to STREAM with address counter (h,v)=(0,0).
  - STREAM: each cycle with stall_in=0, issue a read of (h,v) and push (h,v,valid=1) into a 2-stage sideband pipe.
    - Advance h; at DIM-1, wrap h to 0 and increment v.
    - stall_in=1: no issue and the counter holds. Reads already in flight still emerge two cycles later; stall does not freeze the pipe.
  - Issue of (DIM-1, DIM-1): clear full[rd_sel], toggle rd_sel, go to IDLE at the same edge.
  - Consecutive ready frames therefore have exactly one bubble cycle between them.
- Outputs:
  - data_valid_out, hcount_out and vcount_out come from the sideband pipe, aligned with BRAM data.
  - pixel_data_out holds its last value when valid is 0.
- Latency: the final write is sampled at edge N; full=1 after N; STREAM entered at N+1; address 0 issued in the cycle after N+1; first data_valid_out high after edge N+3. With no stall, DIM*DIM consecutive valid cycles follow.
- frame_done_out is high exactly in the cycle of the valid pixel (DIM-1, DIM-1).
- Simultaneous events:
  - Fill-complete on one bank and stream-complete on the other bank in the same cycle both take effect.
  - The same bank is never both filling and streaming.
  - A write to a bank whose full flag clears this cycle is still dropped, because the check uses the pre-edge flag.
- Reset (any time, including mid-stream):
  - Counters, wr_sel, rd_sel, both full flags and overflow_out all go to 0.
  - State goes to IDLE and the sideband pipe valid bits are cleared.
  - All outputs are 0 the cycle after reset and no partial frame completes.
  - BRAM contents are undefined but unused, because both full flags are 0.

Optional Feature:
- Macro ZERO_PAD_EN.
- When defined:
  - The read counter spans 0..DIM+1 on both axes, giving (DIM+2)^2 valid pixels per frame.
  - Border positions (h or v equal to 0 or DIM+1) output pixel_data_out=0 without a BRAM access, with the same 2-cycle alignment.
  - Interior position (h,v) outputs the stored word (h-1, v-1).
  - hcount_out/vcount_out report padded coordinates.
  - frame_done_out fires on (DIM+1, DIM+1).
- When undefined: unpadded DIM x DIM stream exactly as above; no pad logic is synthesised.

Test Plan:
- Raster fill with value v*24+h, then no stall -> first valid after edge N+3; 576 consecutive valid cycles; pixel (5,3)=77; frame_done_out only with (23,23)=575.
- Fill bank 0, then bank 1 immediately -> two frames separated by exactly one invalid cycle; second frame data correct; overflow_out=0.
- Fill bank 0, bank 1, then write (0,0) while frame 0 is still streaming -> write dropped, overflow_out=1 and sticky; next frame from bank 0 unaffected by the dropped word.
- stall_in high for 10 cycles starting at pixel index 100 -> two in-flight pixels still emerge, then a 10-cycle valid gap; coordinate sequence continuous with no repeats or skips; total 576 valids.
- rst_in pulsed at pixel index 300 -> outputs 0 next cycle; no frame_done_out; no further valids until a fresh full-frame write.
- ZERO_PAD_EN, map of all 7 -> 676 valids; rows 0/25 and columns 0/25 read 0, interior reads 7; frame_done_out with (25,25).
